// File: rtl/accel_spi_sequencer.sv
// Accelerometer command sequencer: init writes, then paced six-register burst reads feeding X/Y/Z samples.
// Latency: one transfer = 1 GO + WAIT until iSPI_END + 1 CAP + GAP_CYC idle; samples update one cycle after the last GAP.
// Backpressure: none; the SPI controller paces via iSPI_END. ACCEL_SEQ_INT_EN adds the DATA_READY init write and iINT pacing.
module accel_spi_sequencer #(
    parameter logic [7:0]  INIT_BW    = 8'h0A,
    parameter logic [7:0]  INIT_FMT   = 8'h0B,
    parameter logic [7:0]  INIT_PWR   = 8'h08,
    parameter int          GAP_CYC    = 4,
    parameter logic [19:0] SAMPLE_DIV = 20'd50000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    output logic [15:0] oP2S_DATA,
    output logic        oSPI_GO,
    input  logic        iSPI_END,
    input  logic [7:0]  iS2P_DATA,
    input  logic        iINT,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic [15:0] oZ,
    output logic        oDATA_VALID,
    output logic        oINIT_DONE
);

`ifdef ACCEL_SEQ_INT_EN
    localparam logic [3:0] PWR_STEP = 4'd3;
`else
    localparam logic [3:0] PWR_STEP = 4'd2;
`endif
    localparam logic [3:0] FIRST_READ = PWR_STEP + 4'd1;
    localparam logic [3:0] LAST_STEP  = FIRST_READ + 4'd5;

    typedef enum logic [2:0] {INIT, GO, WAIT, CAP, GAP, IDLE} state_t;

    state_t      state, nextState;
    logic [3:0]  step;
    logic [7:0]  gapCnt;
    logic        gapDone;
    logic        idleGo;
    logic [2:0]  slot;
    logic [7:0]  rdByte [0:5];

    function automatic logic [15:0] cmdWord(input logic [3:0] s);
        logic       rd;
        logic [5:0] addr;
        logic [7:0] val;
        rd   = 1'b0;
        addr = 6'h2D;
        val  = INIT_PWR;
        if (s >= FIRST_READ) begin
            rd   = 1'b1;
            addr = 6'h32 + 6'(s - FIRST_READ);
            val  = 8'h00;
        end else begin
            case (s)
                4'd0:    begin addr = 6'h2C; val = INIT_BW;  end
                4'd1:    begin addr = 6'h31; val = INIT_FMT; end
`ifdef ACCEL_SEQ_INT_EN
                4'd2:    begin addr = 6'h2E; val = 8'h80;    end
`endif
                default: begin addr = 6'h2D; val = INIT_PWR; end
            endcase
        end
        return {rd, 1'b0, addr, val};
    endfunction

    assign gapDone = (gapCnt == 8'(GAP_CYC - 1));
    assign slot    = 3'(step - FIRST_READ);

`ifdef ACCEL_SEQ_INT_EN
    localparam logic [19:0] unusedDiv = SAMPLE_DIV;
    logic [2:0] intSync;

    always_ff @(posedge iCLK) begin
        if (iRST) intSync <= 3'b000;
        else      intSync <= {intSync[1:0], iINT};
    end

    assign idleGo = intSync[1] & ~intSync[2];
`else
    logic        unusedInt;
    logic [19:0] timer;
    logic        startBurst;

    assign unusedInt  = iINT;
    // Timer restarts as the first read is staged, so GO-to-GO spacing is exactly SAMPLE_DIV.
    assign startBurst = ((state == IDLE) && (nextState == INIT)) ||
                        ((state == GAP) && gapDone && (step == PWR_STEP));
    assign idleGo     = (timer >= SAMPLE_DIV - 20'd1);

    always_ff @(posedge iCLK) begin
        if (iRST)                           timer <= 20'd0;
        else if (startBurst)                timer <= 20'd0;
        else if (timer < SAMPLE_DIV - 20'd1) timer <= timer + 20'd1;
    end
`endif

    always_comb begin
        nextState = state;
        case (state)
            INIT: if (step != 4'd0 || iEN) nextState = GO;
            GO:   nextState = WAIT;
            WAIT: if (iSPI_END) nextState = CAP;
            CAP:  nextState = GAP;
            GAP:  if (gapDone) nextState = (step == LAST_STEP) ? IDLE : INIT;
            IDLE: if (iEN && idleGo) nextState = INIT;
            default: nextState = INIT;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= INIT;
            step        <= 4'd0;
            gapCnt      <= 8'd0;
            oP2S_DATA   <= 16'h0000;
            oSPI_GO     <= 1'b0;
            oX          <= 16'h0000;
            oY          <= 16'h0000;
            oZ          <= 16'h0000;
            oDATA_VALID <= 1'b0;
            oINIT_DONE  <= 1'b0;
            for (int i = 0; i < 6; i++) rdByte[i] <= 8'h00;
        end else begin
            state       <= nextState;
            oSPI_GO     <= (nextState == GO) || (nextState == WAIT) || (nextState == CAP);
            oDATA_VALID <= 1'b0;
            gapCnt      <= (state == GAP) ? gapCnt + 8'd1 : 8'd0;
            if (state == INIT && nextState == GO)
                oP2S_DATA <= cmdWord(step);
            if (state == CAP && step >= FIRST_READ)
                rdByte[slot] <= iS2P_DATA;
            if (state == GAP && gapDone) begin
                if (step == LAST_STEP) begin
                    oX          <= {rdByte[1], rdByte[0]};
                    oY          <= {rdByte[3], rdByte[2]};
                    oZ          <= {rdByte[5], rdByte[4]};
                    oDATA_VALID <= 1'b1;
                    step        <= FIRST_READ;
                end else begin
                    step <= step + 4'd1;
                    if (step == PWR_STEP) oINIT_DONE <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Bench for accel_spi_sequencer: SPI controller responder, event monitor, and directed phases with randomized sensor data.
module tb_accel_spi_sequencer;

    localparam int GAP = 4;
    localparam int DIV = 200;

    logic        clk = 1'b0;
    logic        rst, en, spiEnd, intPin, go, valid, done;
    logic [7:0]  s2p;
    logic [15:0] p2s, x, y, z;

    always #5 clk = ~clk;

    accel_spi_sequencer #(.GAP_CYC(GAP), .SAMPLE_DIV(20'(DIV))) dut (
        .iCLK(clk), .iRST(rst), .iEN(en),
        .oP2S_DATA(p2s), .oSPI_GO(go), .iSPI_END(spiEnd), .iS2P_DATA(s2p),
        .iINT(intPin), .oX(x), .oY(y), .oZ(z),
        .oDATA_VALID(valid), .oINIT_DONE(done)
    );

    int nCmp = 0, nErr = 0, cyc = 0;
    logic [7:0]  regs [0:63];
    logic [15:0] words[$];
    int          burstStarts[$];
    int goRises = 0, lowRun = 0, minLow = 100000, validCount = 0;
    int validRun = 0, maxValidRun = 0, stabErr = 0, doneAtGo = -1, ctlCnt = 0;
    logic doneGoLvl = 1'b1, prevGo = 1'b0, prevDone = 1'b0, seenGo = 1'b0;
    logic [15:0] prevData = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // SPI controller: END one cycle, 16 cycles after GO rises; returns the addressed register byte.
    always @(negedge clk) begin
        if (go) ctlCnt++;
        else    ctlCnt = 0;
        spiEnd = (ctlCnt == 17);
        if (ctlCnt == 17) s2p = regs[p2s[13:8]];
    end

    always @(negedge clk) begin
        if (go && !prevGo) begin
            words.push_back(p2s);
            goRises++;
            if (p2s == 16'hB200) burstStarts.push_back(cyc);
            if (seenGo && lowRun < minLow) minLow = lowRun;
            seenGo = 1'b1;
        end
        if (!go) lowRun++;
        else     lowRun = 0;
        if (go && prevGo && p2s != prevData) stabErr++;
        if (valid) begin
            validCount++;
            validRun++;
            if (validRun > maxValidRun) maxValidRun = validRun;
        end else begin
            validRun = 0;
        end
        if (done && !prevDone && doneAtGo < 0) begin
            doneAtGo  = goRises;
            doneGoLvl = go;
        end
        prevGo   = go;
        prevDone = done;
        prevData = p2s;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] expWord(input int i);
        logic [7:0] a;
        if (i == 0) return 16'h2C0A;
        if (i == 1) return 16'h310B;
        if (i == 2) return 16'h2D08;
        a = 8'h80 | (8'h32 + 8'((i - 3) % 6));
        return {a, 8'h00};
    endfunction

    task automatic checkSample(input string tag);
        check({tag, "_x"}, 32'(x), 32'({regs[8'h33], regs[8'h32]}));
        check({tag, "_y"}, 32'(y), 32'({regs[8'h35], regs[8'h34]}));
        check({tag, "_z"}, 32'(z), 32'({regs[8'h37], regs[8'h36]}));
    endtask

    initial begin
        int vc, gr, enCyc;
        rst = 1'b1; en = 1'b1; intPin = 1'b0; spiEnd = 1'b0; s2p = 8'h00;
        for (int a = 0; a < 64; a++) regs[a] = 8'(a);
        regs[8'h32] = 8'h34; regs[8'h33] = 8'h12; regs[8'h34] = 8'h78;
        regs[8'h35] = 8'h56; regs[8'h36] = 8'hBC; regs[8'h37] = 8'h9A;
        repeat (3) @(negedge clk);
        check("rst_go", 32'(go), 32'd0);
        check("rst_p2s", 32'(p2s), 32'h0);
        check("rst_x", 32'(x), 32'h0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        for (int b = 0; b < 5; b++) begin
            for (int t = 0; t < 2000 && validCount < b + 1; t++) @(negedge clk);
            check("burst_done", 32'(validCount), 32'(b + 1));
            checkSample("sample");
            for (int a = 8'h32; a <= 8'h37; a++) regs[a] = 8'($urandom_range(0, 255));
        end
        check("valid_width", 32'(maxValidRun), 32'd1);
        check("go_low_min", 32'(minLow >= GAP), 32'd1);
        check("p2s_stable", 32'(stabErr), 32'd0);
        check("done_after_init", 32'(doneAtGo), 32'd3);
        check("done_go_low", 32'(doneGoLvl), 32'd0);
        check("done_sticky", 32'(done), 32'd1);
        check("word_count", 32'(words.size()), 32'd33);
        for (int i = 0; i < words.size(); i++) check("word_seq", 32'(words[i]), 32'(expWord(i)));
        check("burst_count", 32'(burstStarts.size()), 32'd5);
        for (int i = 1; i < burstStarts.size(); i++)
            check("period", 32'(burstStarts[i] - burstStarts[i-1]), 32'(DIV));

        // Drop enable during the 0x34 read; the burst still completes, then the block parks.
        for (int t = 0; t < 1000 && !(go && p2s == 16'hB400); t++) @(negedge clk);
        check("reach_b400", 32'(p2s), 32'hB400);
        en = 1'b0;
        @(negedge clk);
        vc = validCount;
        gr = goRises;
        for (int t = 0; t < 500 && validCount < vc + 1; t++) @(negedge clk);
        check("en_low_burst_done", 32'(validCount), 32'(vc + 1));
        checkSample("en_low_sample");
        repeat (400) @(negedge clk);
        check("en_low_one_valid", 32'(validCount), 32'(vc + 1));
        check("en_low_no_go", 32'(goRises), 32'(gr + 3));
        en = 1'b1;
        enCyc = cyc;
        for (int t = 0; t < 10 && !go; t++) @(negedge clk);
        check("restart_delay", 32'(cyc - enCyc), 32'd2);
        check("restart_word", 32'(p2s), 32'hB200);

        // Reset in the middle of the 0x33 read.
        for (int t = 0; t < 400 && !(go && p2s == 16'hB300); t++) @(negedge clk);
        check("reach_b300", 32'(p2s), 32'hB300);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_go", 32'(go), 32'd0);
        check("mid_rst_x", 32'(x), 32'h0);
        check("mid_rst_y", 32'(y), 32'h0);
        check("mid_rst_z", 32'(z), 32'h0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        words.delete();
        rst = 1'b0;
        for (int t = 0; t < 100 && words.size() == 0; t++) @(negedge clk);
        check("post_rst_words", 32'(words.size() > 0), 32'd1);
        check("post_rst_first", 32'(words.size() > 0 ? words[0] : 16'h0), 32'h2C0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
